// File: rtl/jtag_sba_pkg.sv
// Shared types and constants for the system-bus access engine.
package jtag_sba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sba_state_e;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
  localparam logic [2:0] SBERR_BUS     = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  localparam logic [2:0] SBACCESS_8  = 3'd0;
  localparam logic [2:0] SBACCESS_16 = 3'd1;
  localparam logic [2:0] SBACCESS_32 = 3'd2;
  localparam logic [2:0] SBACCESS_64 = 3'd3;

endpackage

// File: rtl/jtag_sba_lane.sv
// Byte-lane steering for the access engine: byte enables, write-data
// replication and read-data alignment/masking for one latched access.
module jtag_sba_lane #(
  parameter  int unsigned DW = 32,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic [2:0]    size_i,
  input  logic [OW-1:0] offset_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] rdata_i,
  output logic [NB-1:0] be_o,
  output logic [DW-1:0] wdata_o,
  output logic [DW-1:0] rdata_o
);

  int unsigned   off;
  int unsigned   nbytes;
  logic [DW-1:0] shifted;

  always_comb begin
    off     = 32'(offset_i);
    nbytes  = 32'd1 << size_i;
    shifted = rdata_i >> {offset_i, 3'b000};
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_o[i]           = (i >= off) && (i < off + nbytes);
      // nbytes is a power of two, so the mask picks the source byte modulo the access size
      wdata_o[8*i +: 8] = wdata_i[8*(i & (nbytes - 1)) +: 8];
      rdata_o[8*i +: 8] = (i < nbytes) ? shifted[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/jtag_sba_ctrl.sv
// System-bus access engine: sbaddress/sbdata handling, start checks, sticky
// errors and req/gnt/rvalid sequencing. Optional watchdog: SBA_TIMEOUT_EN.
module jtag_sba_ctrl
  import jtag_sba_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   sbaddress_i,
  input  logic            sbaddress_we_i,
  output logic [AW-1:0]   sbaddress_o,
  input  logic [DW-1:0]   sbdata_i,
  input  logic            sbdata_we_i,
  input  logic            sbdata_re_i,
  output logic [DW-1:0]   sbdata_o,
  input  logic            sbreadonaddr_i,
  input  logic            sbreadondata_i,
  input  logic            sbautoincrement_i,
  input  logic [2:0]      sbaccess_i,
  input  logic [2:0]      sberror_clr_i,
  input  logic            sbbusyerror_clr_i,
  output logic            sbbusy_o,
  output logic [2:0]      sberror_o,
  output logic            sbbusyerror_o,
  output logic            master_req_o,
  input  logic            master_gnt_i,
  input  logic            master_rvalid_i,
  output logic            master_we_o,
  output logic [DW/8-1:0] master_be_o,
  output logic [AW-1:0]   master_addr_o,
  output logic [DW-1:0]   master_wdata_o,
  input  logic [DW-1:0]   master_rdata_i,
  input  logic            master_err_i
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);

  sba_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [2:0]    err_q, err_d, size_q, size_d;
  logic          berr_q, berr_d, we_q, we_d;
  logic [OW-1:0] off_q, off_d;

  logic [NB-1:0] lane_be;
  logic [DW-1:0] lane_wdata, lane_rdata;
  logic [AW-1:0] start_addr;
  logic [OW-1:0] align_mask;
  logic          busy, blocked, wr_trig, rd_trig, size_bad, align_bad, timeout;

  jtag_sba_lane #(.DW(DW)) u_lane (
    .size_i   (size_q),
    .offset_i (off_q),
    .wdata_i  (wdata_q),
    .rdata_i  (master_rdata_i),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

`ifdef SBA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // REQ is only entered from IDLE, where the count is held at zero
  always_comb begin
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    timeout = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    off_d   = off_q;

    busy       = (state_q != IDLE);
    blocked    = (err_q != SBERR_NONE) || berr_q;
    wr_trig    = sbdata_we_i;
    rd_trig    = (sbaddress_we_i && sbreadonaddr_i) || (sbdata_re_i && sbreadondata_i);
    start_addr = sbaddress_we_i ? sbaddress_i : addr_q;
    size_bad   = 32'(sbaccess_i) > OW;
    align_mask = OW'((32'd1 << sbaccess_i) - 32'd1);
    align_bad  = |(start_addr[OW-1:0] & align_mask);

    // Clears first so that an error raised in the same cycle survives
    err_d  = err_q & ~sberror_clr_i;
    berr_d = berr_q & ~sbbusyerror_clr_i;
    if (busy && (sbaddress_we_i || sbdata_we_i || sbdata_re_i)) berr_d = 1'b1;
    if (!busy && sbaddress_we_i) addr_d = sbaddress_i;

    case (state_q)
      IDLE: begin
        if (!blocked && (wr_trig || rd_trig)) begin
          if (size_bad)       err_d = SBERR_SIZE;
          else if (align_bad) err_d = SBERR_ALIGN;
          else begin
            state_d = REQ;
            we_d    = wr_trig;
            size_d  = sbaccess_i;
            off_d   = start_addr[OW-1:0];
            wdata_d = sbdata_i;
          end
        end
      end
      REQ: begin
        if (master_gnt_i) state_d = WAIT;
        else if (timeout) begin
          state_d = IDLE;
          err_d   = SBERR_TIMEOUT;
        end
      end
      WAIT: begin
        if (master_rvalid_i) begin
          state_d = IDLE;
          if (master_err_i) err_d = SBERR_BUS;
          else begin
            if (!we_q) rdata_d = lane_rdata;
            if (sbautoincrement_i) addr_d = addr_q + AW'(32'd1 << size_q);
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = SBERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      err_q   <= SBERR_NONE;
      berr_q  <= 1'b0;
      size_q  <= SBACCESS_8;
      we_q    <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      berr_q  <= berr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      off_q   <= off_d;
    end
  end

  assign sbaddress_o    = addr_q;
  assign sbdata_o       = rdata_q;
  assign sbbusy_o       = (state_q != IDLE);
  assign sberror_o      = err_q;
  assign sbbusyerror_o  = berr_q;
  assign master_req_o   = (state_q == REQ);
  assign master_we_o    = master_req_o && we_q;
  assign master_be_o    = master_req_o ? lane_be : '0;
  assign master_addr_o  = addr_q & ~AW'(NB - 1);
  assign master_wdata_o = lane_wdata;

endmodule

// File: tb/tb_jtag_sba_ctrl.sv
// Directed bench for jtag_sba_ctrl: a 32-bit and a 64-bit engine driven with
// hand-computed vectors; timeout checks follow SBA_TIMEOUT_EN.
module tb_jtag_sba_ctrl;

`ifdef SBA_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [31:0] sbaddress_i, sbaddress_o, sbdata_i, sbdata_o, m_addr, m_wdata, m_rdata;
  logic        sbaddress_we, sbdata_we, sbdata_re, rdonaddr, rdondata, autoinc;
  logic [2:0]  sbaccess, err_clr, sberror;
  logic        berr_clr, busy, berr, m_req, m_gnt, m_rvalid, m_we, m_err;
  logic [3:0]  m_be;

  // 64-bit instance
  logic [31:0] w_sbaddress_i, w_sbaddress_o, w_m_addr;
  logic [63:0] w_sbdata_i, w_sbdata_o, w_m_wdata, w_m_rdata;
  logic        w_sbaddress_we, w_sbdata_we, w_rdonaddr;
  logic [2:0]  w_sbaccess, w_sberror;
  logic        w_busy, w_berr, w_m_req, w_m_gnt, w_m_rvalid, w_m_we;
  logic [7:0]  w_m_be;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_acc    = 0;

  jtag_sba_ctrl #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .sbaddress_i(sbaddress_i), .sbaddress_we_i(sbaddress_we), .sbaddress_o(sbaddress_o),
    .sbdata_i(sbdata_i), .sbdata_we_i(sbdata_we), .sbdata_re_i(sbdata_re), .sbdata_o(sbdata_o),
    .sbreadonaddr_i(rdonaddr), .sbreadondata_i(rdondata), .sbautoincrement_i(autoinc),
    .sbaccess_i(sbaccess), .sberror_clr_i(err_clr), .sbbusyerror_clr_i(berr_clr),
    .sbbusy_o(busy), .sberror_o(sberror), .sbbusyerror_o(berr),
    .master_req_o(m_req), .master_gnt_i(m_gnt), .master_rvalid_i(m_rvalid),
    .master_we_o(m_we), .master_be_o(m_be), .master_addr_o(m_addr),
    .master_wdata_o(m_wdata), .master_rdata_i(m_rdata), .master_err_i(m_err)
  );

  jtag_sba_ctrl #(.AW(32), .DW(64), .TIMEOUT_CYC(256)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .sbaddress_i(w_sbaddress_i), .sbaddress_we_i(w_sbaddress_we), .sbaddress_o(w_sbaddress_o),
    .sbdata_i(w_sbdata_i), .sbdata_we_i(w_sbdata_we), .sbdata_re_i(1'b0), .sbdata_o(w_sbdata_o),
    .sbreadonaddr_i(w_rdonaddr), .sbreadondata_i(1'b0), .sbautoincrement_i(1'b0),
    .sbaccess_i(w_sbaccess), .sberror_clr_i(3'b000), .sbbusyerror_clr_i(1'b0),
    .sbbusy_o(w_busy), .sberror_o(w_sberror), .sbbusyerror_o(w_berr),
    .master_req_o(w_m_req), .master_gnt_i(w_m_gnt), .master_rvalid_i(w_m_rvalid),
    .master_we_o(w_m_we), .master_be_o(w_m_be), .master_addr_o(w_m_addr),
    .master_wdata_o(w_m_wdata), .master_rdata_i(w_m_rdata), .master_err_i(1'b0)
  );

  always @(posedge clk) if (m_req && m_gnt) n_acc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_addr(input logic [31:0] a, input logic rd);
    sbaddress_i = a; sbaddress_we = 1'b1; rdonaddr = rd;
    tick();
    sbaddress_we = 1'b0; rdonaddr = 1'b0;
  endtask

  task automatic pulse_wdata(input logic [31:0] d);
    sbdata_i = d; sbdata_we = 1'b1;
    tick();
    sbdata_we = 1'b0;
  endtask

  task automatic clr_err(input logic [2:0] m);
    err_clr = m;
    tick();
    err_clr = 3'b000;
  endtask

  // Grant the pending request, then answer on the following cycle
  task automatic bus32(input logic e, input logic [31:0] rd);
    int unsigned n = 0;
    while (!m_req && n < 20) begin tick(); n++; end
    check("bus_req_seen", m_req, 1'b1);
    if (!m_req) return;
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = rd; m_err = e;
    tick();
    m_rvalid = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned acc0;
    rst_n = 1'b0;
    sbaddress_i = '0; sbaddress_we = 0; sbdata_i = '0; sbdata_we = 0; sbdata_re = 0;
    rdonaddr = 0; rdondata = 0; autoinc = 0; sbaccess = 3'd0; err_clr = 3'd0; berr_clr = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0; m_err = 0;
    w_sbaddress_i = '0; w_sbaddress_we = 0; w_sbdata_i = '0; w_sbdata_we = 0; w_rdonaddr = 0;
    w_sbaccess = 3'd0; w_m_gnt = 0; w_m_rvalid = 0; w_m_rdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_sbaddress", sbaddress_o, 32'h0);
    check("rst_sbdata", sbdata_o, 32'h0);
    check("rst_sberror", sberror, 3'd0);
    check("rst_busyerr", berr, 1'b0);
    check("rst_req_we_be", {m_req, m_we, m_be}, 6'b0);
    check("rst_busy", busy, 1'b0);

    // Byte write at offset 3 with autoincrement
    sbaccess = 3'd0; autoinc = 1'b1;
    pulse_addr(32'h1000_0003, 1'b0);
    check("t1_addr_load", sbaddress_o, 32'h1000_0003);
    pulse_wdata(32'hFFFF_FFA5);
    check("t1_req", {m_req, m_we, busy}, 3'b111);
    check("t1_be", m_be, 4'b1000);
    check("t1_addr", m_addr, 32'h1000_0000);
    check("t1_wdata", m_wdata, 32'hA5A5_A5A5);
    m_gnt = 1'b1; tick(); m_gnt = 1'b0;
    check("t1_wait", {m_req, busy}, 2'b01);
    m_rvalid = 1'b1; tick(); m_rvalid = 1'b0;
    check("t1_done_busy", busy, 1'b0);
    check("t1_autoinc", sbaddress_o, 32'h1000_0004);
    check("t1_sberror", sberror, 3'd0);

    // Halfword read on address write
    autoinc = 1'b0; sbaccess = 3'd1;
    pulse_addr(32'h2000_0002, 1'b1);
    check("t2_req", {m_req, m_we}, 2'b10);
    check("t2_be", m_be, 4'b1100);
    check("t2_addr", m_addr, 32'h2000_0000);
    bus32(1'b0, 32'hBEEF_1234);
    check("t2_rdata", sbdata_o, 32'h0000_BEEF);
    check("t2_err_busy", {sberror, busy}, 4'b0);
    check("t2_addr_hold", sbaddress_o, 32'h2000_0002);

    m_rvalid = 1'b1; m_rdata = 32'hDEAD_DEAD; tick(); m_rvalid = 1'b0;
    check("stray_rvalid", sbdata_o, 32'h0000_BEEF);

    // Byte read on data read
    sbaccess = 3'd0; rdondata = 1'b1;
    sbdata_re = 1'b1; tick(); sbdata_re = 1'b0; rdondata = 1'b0;
    check("t2b_be", m_be, 4'b0100);
    bus32(1'b0, 32'h11AA_2233);
    check("t2b_rdata", sbdata_o, 32'h0000_00AA);

    // Misaligned word access
    sbaccess = 3'd2;
    pulse_addr(32'h3000_0002, 1'b1);
    check("t3_align_err", sberror, 3'd3);
    check("t3_no_req", {m_req, busy}, 2'b00);
    sbaccess = 3'd0;
    pulse_wdata(32'h0);
    check("t3_blocked", {m_req, sberror}, {1'b0, 3'd3});
    clr_err(3'b001);
    check("t3_partial_clr", sberror, 3'd2);
    clr_err(3'b111);
    check("t3_clr", sberror, 3'd0);

    // Doubleword on a 32-bit bus
    sbaccess = 3'd3;
    pulse_addr(32'h3000_0000, 1'b0);
    pulse_wdata(32'h0);
    check("t4_size_err", {m_req, sberror}, {1'b0, 3'd4});
    clr_err(3'b111);

    // Busy error
    sbaccess = 3'd2; acc0 = n_acc;
    pulse_wdata(32'h1234_5678);
    check("t6_req", m_req, 1'b1);
    pulse_wdata(32'h0);
    check("t6_busyerr", {berr, m_req}, 2'b11);
    berr_clr = 1'b1;
    pulse_addr(32'h0000_0044, 1'b0);
    berr_clr = 1'b0;
    check("t6_set_beats_clr", berr, 1'b1);
    check("t6_addr_kept", sbaddress_o, 32'h3000_0000);
    bus32(1'b0, 32'h0);
    check("t6_one_access", n_acc - acc0, 32'd1);
    pulse_wdata(32'h0);
    check("t6_blocked", {m_req, busy}, 2'b00);
    berr_clr = 1'b1; tick(); berr_clr = 1'b0;
    check("t6_berr_clr", berr, 1'b0);
    pulse_wdata(32'h0);
    check("t6_restart", m_req, 1'b1);
    bus32(1'b0, 32'h0);

    // Bus error suppresses autoincrement
    autoinc = 1'b1;
    pulse_wdata(32'h0);
    bus32(1'b1, 32'h0);
    check("t7_bus_err", sberror, 3'd2);
    check("t7_no_inc", sbaddress_o, 32'h3000_0000);
    clr_err(3'b111);
    autoinc = 1'b0;

    // Grant withheld
    pulse_wdata(32'h0);
    check("t8_req", m_req, 1'b1);
`ifdef SBA_TIMEOUT_EN
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("t8_tmo_cycles", n, 32'd8);
    check("t8_tmo_err", {sberror, m_req}, {3'd1, 1'b0});
    m_rvalid = 1'b1; m_err = 1'b1; tick(); m_rvalid = 1'b0; m_err = 1'b0;
    check("t8_late_rvalid", sberror, 3'd1);
    clr_err(3'b111);
`else
    n = 0;
    repeat (40) tick();
    check("t8_still_wait", {busy, m_req, sberror}, {2'b11, 3'd0});
    bus32(1'b0, 32'h0);
    check("t8_release", busy, 1'b0);
`endif

    // 64-bit bus
    w_sbaccess = 3'd3;
    w_sbaddress_i = 32'h0000_0008; w_sbaddress_we = 1'b1; tick(); w_sbaddress_we = 1'b0;
    w_sbdata_i = 64'h1122_3344_5566_7788; w_sbdata_we = 1'b1; tick(); w_sbdata_we = 1'b0;
    check("w_be", w_m_be, 8'hFF);
    check("w_addr", w_m_addr, 32'h0000_0008);
    check("w_wdata", w_m_wdata, 64'h1122_3344_5566_7788);
    check("w_we", {w_m_req, w_m_we}, 2'b11);
    w_m_gnt = 1'b1; tick(); w_m_gnt = 1'b0;
    w_m_rvalid = 1'b1; tick(); w_m_rvalid = 1'b0;
    check("w_done", {w_busy, w_sberror}, 4'b0);

    w_sbaccess = 3'd2;
    w_sbaddress_i = 32'h0000_000C; w_sbaddress_we = 1'b1; w_rdonaddr = 1'b1;
    tick();
    w_sbaddress_we = 1'b0; w_rdonaddr = 1'b0;
    check("w_rd_be", w_m_be, 8'hF0);
    check("w_rd_addr", w_m_addr, 32'h0000_0008);
    w_m_gnt = 1'b1; tick(); w_m_gnt = 1'b0;
    w_m_rvalid = 1'b1; w_m_rdata = 64'hCAFE_F00D_1234_5678; tick(); w_m_rvalid = 1'b0;
    check("w_rdata", w_sbdata_o, 64'h0000_0000_CAFE_F00D);

    w_sbaccess = 3'd4;
    w_sbdata_we = 1'b1; tick(); w_sbdata_we = 1'b0;
    check("w_size_err", {w_m_req, w_sberror}, {1'b0, 3'd4});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
